// File: rtl/student_sample_dma.sv
// Streaming TL-UL host: queues audio samples and writes them as 32-bit PutFullData into a circular buffer.
// Optional build macro STUDENT_DMA_PACK_EN packs two 16-bit samples per bus word.
package tlul_pkg;
    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module student_sample_dma #(
    parameter int DATA_SIZE  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int SOURCE_ID  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [31:0]          base_addr_i,
    input  logic [15:0]          len_words_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic                 valid_strobe_i,
    output tlul_pkg::tl_h2d_t    tl_host_o,
    input  tlul_pkg::tl_d2h_t    tl_host_i,
    output logic [15:0]          wr_idx_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic                 bus_error_o,
    output logic                 wrap_irq_o
);
    import tlul_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e      state_q, state_d;
    tl_h2d_t     a_q;
    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [15:0] wr_idx_q, idx_d, len_eff;
    logic [16:0] idx_inc;
    logic [31:0] sample_ext, push_word, a_addr_d;
    logic        en_q, en_rise, fifo_empty, fifo_full;
    logic        push_req, push_ok, pop, drop, flush, load_a;
    logic        idx_adv, idx_wrap;
    logic        overflow_q, bus_error_q, wrap_irq_q;
    logic        unused_in;

    assign sample_ext = 32'($signed(sample_i));
    assign en_rise    = enable_i & ~en_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef STUDENT_DMA_PACK_EN
    logic [15:0] half_q;
    logic        half_vld_q;
    logic        unused_pack;

    assign push_req    = enable_i & valid_strobe_i & half_vld_q;
    assign push_word   = {sample_ext[15:0], half_q};
    assign unused_pack = ^sample_ext[31:16];

    // The pending low half-word is dropped as soon as capture is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            half_q     <= '0;
            half_vld_q <= 1'b0;
        end else if (!enable_i) begin
            half_vld_q <= 1'b0;
        end else if (valid_strobe_i) begin
            half_q     <= sample_ext[15:0];
            half_vld_q <= ~half_vld_q;
        end
    end
`else
    assign push_req  = enable_i & valid_strobe_i;
    assign push_word = sample_ext;
`endif

    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign pop     = (state_q == REQ) & tl_host_i.a_ready;
    assign push_ok = push_req & (~fifo_full | pop);
    assign drop    = push_req & fifo_full & ~pop;
    assign flush   = ~enable_i & ((state_q == IDLE) | ((state_q == RESP) & tl_host_i.d_valid));

    // NOTE: sample storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wr_ptr_q[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Index math uses >= so a shortened buffer wraps on the next increment.
    assign len_eff  = (len_words_i == 16'd0) ? 16'd1 : len_words_i;
    assign idx_inc  = {1'b0, wr_idx_q} + 17'd1;
    assign idx_wrap = (idx_inc >= {1'b0, len_eff});
    assign idx_adv  = (state_q == RESP) & tl_host_i.d_valid;
    assign idx_d    = en_rise ? 16'd0 : idx_adv ? (idx_wrap ? 16'd0 : idx_inc[15:0]) : wr_idx_q;
    assign a_addr_d = {base_addr_i[31:2], 2'b00} + {14'd0, idx_d, 2'b00};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        load_a  = 1'b0;
        unique case (state_q)
            IDLE: if (!fifo_empty && enable_i) begin
                state_d = REQ;
                load_a  = 1'b1;
            end
            REQ:  if (tl_host_i.a_ready) state_d = RESP;
            RESP: if (tl_host_i.d_valid) begin
                if (!fifo_empty && enable_i) begin
                    state_d = REQ;
                    load_a  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            wr_idx_q    <= '0;
            overflow_q  <= 1'b0;
            bus_error_q <= 1'b0;
            wrap_irq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= enable_i;
            wr_idx_q   <= idx_d;
            wrap_irq_q <= idx_adv & idx_wrap & ~en_rise;
            if (en_rise) begin
                overflow_q  <= 1'b0;
                bus_error_q <= 1'b0;
            end else begin
                if (drop) overflow_q <= 1'b1;
                if (idx_adv && tl_host_i.d_error) bus_error_q <= 1'b1;
            end
        end
    end

    // A-channel is held in flops so it cannot change while waiting for a_ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q          <= '0;
            a_q.a_opcode <= PutFullData;
        end else if (load_a) begin
            a_q.a_valid   <= 1'b1;
            a_q.a_opcode  <= PutFullData;
            a_q.a_param   <= 3'd0;
            a_q.a_size    <= 2'd2;
            a_q.a_source  <= 8'(SOURCE_ID);
            a_q.a_address <= a_addr_d;
            a_q.a_mask    <= 4'hF;
            a_q.a_data    <= fifo_mem[rd_ptr_q[AW-1:0]];
        end else if (pop) begin
            a_q.a_valid <= 1'b0;
        end
    end

    always_comb begin
        tl_host_o         = a_q;
        tl_host_o.d_ready = (state_q == RESP);
    end

    assign wr_idx_o    = wr_idx_q;
    assign busy_o      = (state_q != IDLE) | ~fifo_empty;
    assign overflow_o  = overflow_q;
    assign bus_error_o = bus_error_q;
    assign wrap_irq_o  = wrap_irq_q;

    assign unused_in = ^{tl_host_i.d_opcode, tl_host_i.d_param, tl_host_i.d_size, tl_host_i.d_source,
                         tl_host_i.d_sink, tl_host_i.d_data, base_addr_i[1:0]};
endmodule

// File: tb/tb_student_sample_dma.sv
// Directed self-checking bench for student_sample_dma; the host's bus partner is driven by hand.
// With STUDENT_DMA_PACK_EN defined only the packing scenario is exercised.
module tb_student_sample_dma;
    import tlul_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic [31:0] base_addr_i = BASE;
    logic [15:0] len_words_i = 16'd4;
    logic [15:0] sample_i = '0;
    logic        valid_strobe_i = 1'b0;
    tl_h2d_t     h2d;
    tl_d2h_t     d2h = '0;
    logic [15:0] wr_idx_o;
    logic        busy_o, overflow_o, bus_error_o, wrap_irq_o;

    int passed = 0;
    int total  = 0;
    logic stable;

    student_sample_dma #(.DATA_SIZE(16), .FIFO_DEPTH(8), .SOURCE_ID(0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
        .base_addr_i(base_addr_i), .len_words_i(len_words_i),
        .sample_i(sample_i), .valid_strobe_i(valid_strobe_i),
        .tl_host_o(h2d), .tl_host_i(d2h),
        .wr_idx_o(wr_idx_o), .busy_o(busy_o), .overflow_o(overflow_o),
        .bus_error_o(bus_error_o), .wrap_irq_o(wrap_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic strobe(input logic [15:0] s);
        sample_i       = s;
        valid_strobe_i = 1'b1;
        tick();
        valid_strobe_i = 1'b0;
    endtask

    // Waits for a request, checks it, accepts it and answers one cycle later.
    task automatic complete_write(input string tag, input logic [31:0] addr,
                                  input logic [31:0] data, input logic err);
        for (int i = 0; i < 50 && !h2d.a_valid; i++) tick();
        check({tag, "_a_valid"}, 32'(h2d.a_valid), 32'd1);
        check({tag, "_addr"}, h2d.a_address, addr);
        check({tag, "_data"}, h2d.a_data, data);
        check({tag, "_fmt"}, {21'd0, h2d.a_opcode, h2d.a_size, h2d.a_mask, 2'(h2d.a_source)},
              {21'd0, 3'h0, 2'd2, 4'hF, 2'd0});
        d2h.a_ready = 1'b1;
        tick();
        d2h.a_ready = 1'b0;
        check({tag, "_resp_state"}, {30'd0, h2d.a_valid, h2d.d_ready}, 32'b01);
        d2h.d_valid = 1'b1;
        d2h.d_error = err;
        tick();
        d2h.d_valid = 1'b0;
        d2h.d_error = 1'b0;
    endtask

    task automatic reenable();
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_a_valid", 32'(h2d.a_valid), 32'd0);
        check("rst_d_ready", 32'(h2d.d_ready), 32'd0);
        check("rst_a_fields", h2d.a_address | h2d.a_data | 32'(h2d.a_opcode), 32'd0);
        check("rst_wr_idx", 32'(wr_idx_o), 32'd0);
        check("rst_flags", {27'd0, busy_o, overflow_o, bus_error_o, wrap_irq_o, 1'b0}, 32'd0);
        rst_ni = 1'b1;
        tick();
        enable_i = 1'b1;
        tick();

`ifdef STUDENT_DMA_PACK_EN
        strobe(16'h1234);
        strobe(16'hABCD);
        check("pack_latency_t1", 32'(h2d.a_valid), 32'd0);
        tick();
        complete_write("pack", BASE, 32'hABCD_1234, 1'b0);
        check("pack_wr_idx", 32'(wr_idx_o), 32'd1);
        check("pack_busy", 32'(busy_o), 32'd0);
`else
        // Single sample and request latency.
        strobe(16'h8001);
        check("single_t1_a_valid", 32'(h2d.a_valid), 32'd0);
        check("single_t1_busy", 32'(busy_o), 32'd1);
        tick();
        check("single_t2_a_valid", 32'(h2d.a_valid), 32'd1);
        complete_write("single", BASE, 32'hFFFF_8001, 1'b0);
        check("single_wr_idx", 32'(wr_idx_o), 32'd1);
        check("single_busy", 32'(busy_o), 32'd0);

        // Wrap over a 4-word buffer with five samples.
        reenable();
        check("wrap_idx_cleared", 32'(wr_idx_o), 32'd0);
        strobe(16'h0001);
        strobe(16'h0002);
        strobe(16'h7FFF);
        strobe(16'hFFFE);
        strobe(16'h0005);
        complete_write("wrap0", BASE, 32'h0000_0001, 1'b0);
        check("wrap0_irq_idx", {wrap_irq_o, 15'd0, wr_idx_o}, {1'b0, 15'd0, 16'd1});
        check("wrap0_b2b", 32'(h2d.a_valid), 32'd1);
        complete_write("wrap1", BASE + 32'h4, 32'h0000_0002, 1'b0);
        check("wrap1_irq_idx", {wrap_irq_o, 15'd0, wr_idx_o}, {1'b0, 15'd0, 16'd2});
        complete_write("wrap2", BASE + 32'h8, 32'h0000_7FFF, 1'b0);
        check("wrap2_irq_idx", {wrap_irq_o, 15'd0, wr_idx_o}, {1'b0, 15'd0, 16'd3});
        complete_write("wrap3", BASE + 32'hC, 32'hFFFF_FFFE, 1'b0);
        check("wrap3_irq_idx", {wrap_irq_o, 15'd0, wr_idx_o}, {1'b1, 15'd0, 16'd0});
        complete_write("wrap4", BASE, 32'h0000_0005, 1'b0);
        check("wrap4_irq_idx", {wrap_irq_o, 15'd0, wr_idx_o}, {1'b0, 15'd0, 16'd1});

        // Error on the second response is sticky; the index keeps moving.
        reenable();
        strobe(16'h0100);
        strobe(16'h0200);
        strobe(16'h0300);
        complete_write("err0", BASE, 32'h0000_0100, 1'b0);
        check("err0_flag", 32'(bus_error_o), 32'd0);
        complete_write("err1", BASE + 32'h4, 32'h0000_0200, 1'b1);
        check("err1_flag", 32'(bus_error_o), 32'd1);
        complete_write("err2", BASE + 32'h8, 32'h0000_0300, 1'b0);
        check("err2_sticky", 32'(bus_error_o), 32'd1);
        check("err2_wr_idx", 32'(wr_idx_o), 32'd3);

        // Backpressure for 20 cycles with 12 strobes into an 8-entry FIFO.
        len_words_i = 16'd16;
        reenable();
        check("bp_flags_cleared", {30'd0, overflow_o, bus_error_o}, 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 12) strobe(16'h0010 + 16'(i));
            else tick();
            if (i >= 1)
                stable &= h2d.a_valid && (h2d.a_address == BASE) && (h2d.a_data == 32'h10);
        end
        check("bp_a_stable", 32'(stable), 32'd1);
        check("bp_overflow", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 8; i++)
            complete_write("bp", BASE + 32'(4 * i), 32'h10 + 32'(i), 1'b0);
        check("bp_no_extra", {30'd0, h2d.a_valid, busy_o}, 32'd0);
        check("bp_wr_idx", 32'(wr_idx_o), 32'd8);

        // Disable while a request is waiting with three more queued.
        reenable();
        check("dis_cleared", {overflow_o, 15'd0, wr_idx_o}, 32'd0);
        strobe(16'h0A00);
        strobe(16'h0A01);
        strobe(16'h0A02);
        strobe(16'h0A03);
        check("dis_in_req", 32'(h2d.a_valid), 32'd1);
        enable_i = 1'b0;
        tick();
        tick();
        check("dis_a_held", 32'(h2d.a_valid), 32'd1);
        complete_write("dis", BASE, 32'h0000_0A00, 1'b0);
        check("dis_busy_low", {30'd0, busy_o, h2d.a_valid}, 32'd0);
        strobe(16'h0BAD);
        tick();
        tick();
        check("dis_quiet", {30'd0, busy_o, h2d.a_valid}, 32'd0);
        check("dis_wr_idx", 32'(wr_idx_o), 32'd1);
        enable_i = 1'b1;
        tick();
        check("dis_reenable_idx", 32'(wr_idx_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: observed timeout expected finish");
    end
endmodule
